// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract controller.
// Latches two WIDTH-bit operands and an op code, then feeds one shared
// full add/subtract cell one bit per clock (LSB first). The result and the
// carry/borrow, overflow and zero flags are registered only on the edge that
// handles the final bit, so the outputs never show partial values.
module serial_addsub_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    // One extra counter bit so the counter cannot wrap before bit WIDTH-1.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] sa;       // first operand, shifted right each bit
    logic [WIDTH-1:0] sb;       // second operand (inverted for subtract)
    logic [WIDTH-1:0] sr;       // partial result, filled from the MSB end
    logic [WIDTH-1:0] sr_next;
    logic [CNT_W-1:0] cnt;      // index of the bit handled on the next edge
    logic             c;        // carry into the current bit
    logic             c_next;   // carry out of the current bit
    logic             s;        // sum bit of the current bit
    logic             op_q;     // latched op code
    logic             last_bit; // this edge processes bit WIDTH-1

    // Sum output of the shared full add cell.
    function automatic logic cell_sum(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    // Carry output of the shared full add cell (majority of the three inputs).
    function automatic logic cell_carry(input logic a, input logic b, input logic ci);
        return (a & b) | (a & ci) | (b & ci);
    endfunction

    // Shared cell and next partial result for the bit currently at position 0.
    always_comb begin
        s        = cell_sum(sa[0], sb[0], c);
        c_next   = cell_carry(sa[0], sb[0], c);
        sr_next  = {s, sr[WIDTH-1:1]};
        last_bit = (state == RUN) && (cnt == LAST_BIT);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only from IDLE, leave RUN after the last bit,
    // and spend exactly one cycle in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (init) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture and bit-serial shifting; reset discards any partial work.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa   <= '0;
            sb   <= '0;
            sr   <= '0;
            cnt  <= '0;
            c    <= 1'b0;
            op_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init) begin
                        // Subtract as A + ~B + 1: invert B and preload carry.
                        sa   <= A;
                        sb   <= op ? ~B : B;
                        c    <= op;
                        op_q <= op;
                        cnt  <= '0;
                        sr   <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_next;
                    c   <= c_next;
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Result and flag registers, updated only when the final bit completes.
    // On that edge c is the carry into the MSB and c_next the carry out,
    // so their difference is the signed overflow. For subtract the adder
    // carry is the inverse of the borrow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (last_bit) begin
            result <= sr_next;
            cout   <= c_next ^ op_q;
            ovf    <= c ^ c_next;
            zero   <= (sr_next == '0);
        end
    end

    // Moore status outputs decoded from the registered state.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: self-checking bench for serial_addsub_ctrl (WIDTH=4).
// Expected values come from plain integer arithmetic on the operands.
module tb_serial_addsub_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         init;
    logic         op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         busy;
    logic         done;

    int n_checks;
    int n_errors;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .op     (op_i),
        .A      (a_i),
        .B      (b_i),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: modulo-2^W arithmetic on integers, signed range for overflow.
    task automatic model(input int a, input int b, input logic o,
                         output logic [W-1:0] res, output logic co,
                         output logic ov, output logic z);
        int full, sa, sb, sres;
        full = o ? (a - b) : (a + b);
        res  = W'(full & ((1 << W) - 1));
        co   = o ? (a < b) : (full >= (1 << W));
        sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        sres = o ? (sa - sb) : (sa + sb);
        ov   = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
        z    = (res == '0);
    endtask

    // One complete operation; optionally scrambles inputs after acceptance.
    task automatic run_op(input int a, input int b, input logic o, input bit scramble);
        int           edges;
        logic [W-1:0] er, prev;
        logic         ec, eo, ez;
        model(a, b, o, er, ec, eo, ez);
        @(negedge clk);
        a_i  = W'(a);
        b_i  = W'(b);
        op_i = o;
        init = 1'b1;
        prev = result;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        init = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        if (scramble) begin
            a_i  = W'($urandom);
            b_i  = W'($urandom);
            op_i = 1'($urandom);
        end
        while (done !== 1'b1 && edges < W + 10) begin
            check("result_stable_in_run", 32'(result), 32'(prev));
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency_edges", 32'(edges), 32'(W + 1));
        check("result", 32'(result), 32'(er));
        check("cout", 32'(cout), 32'(ec));
        check("ovf", 32'(ovf), 32'(eo));
        check("zero", 32'(zero), 32'(ez));
        check("busy_low_in_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("result_held", 32'(result), 32'(er));
    endtask

    initial begin
        int           ndone, cyc, last;
        logic [W-1:0] er, got_res;
        logic         ec, eo, ez;

        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        init = 1'b0;
        op_i = 1'b0;
        a_i  = '0;
        b_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {28'd0, cout, ovf, zero, 1'b0}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Directed cases.
        run_op(5, 3, 1'b0, 1'b0);
        check("tp_5p3_result", 32'(result), 32'd8);
        run_op(3, 5, 1'b1, 1'b0);
        check("tp_3m5_result", 32'(result), 32'd14);
        run_op(7, 7, 1'b1, 1'b0);
        run_op(15, 1, 1'b0, 1'b0);
        run_op(8, 1, 1'b1, 1'b0);
        check("tp_8m1_ovf", 32'(ovf), 32'd1);

        // init re-pulsed and operands changed mid-RUN: no restart.
        @(negedge clk);
        a_i = 4'd9; b_i = 4'd4; op_i = 1'b0; init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_i = 4'd2; b_i = 4'd2; op_i = 1'b1; init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        ndone = 0;
        got_res = '0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                got_res = result;
            end
        end
        model(9, 4, 1'b0, er, ec, eo, ez);
        check("midrun_done_count", 32'(ndone), 32'd1);
        check("midrun_result", 32'(got_res), 32'(er));

        // Asynchronous reset at the 2nd RUN edge.
        run_op(6, 5, 1'b0, 1'b0);
        @(negedge clk);
        a_i = 4'd3; b_i = 4'd2; op_i = 1'b0; init = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_result", 32'(result), 32'd0);
        check("arst_flags", {28'd0, cout, ovf, zero, 1'b0}, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        run_op(3, 2, 1'b0, 1'b0);

        // Continuous init: one completion every W+2 cycles.
        @(negedge clk);
        a_i = 4'd10; b_i = 4'd7; op_i = 1'b1; init = 1'b1;
        model(10, 7, 1'b1, er, ec, eo, ez);
        cyc = 0;
        last = -1;
        ndone = 0;
        repeat (4 * (W + 2) + 2) begin
            @(negedge clk);
            cyc++;
            if (busy && done) check("busy_done_exclusive", 32'd1, 32'd0);
            if (done) begin
                if (last >= 0) check("hold_period", 32'(cyc - last), 32'(W + 2));
                check("hold_result", 32'(result), 32'(er));
                last = cyc;
                ndone++;
            end
        end
        check("hold_done_count", 32'(ndone), 32'd4);
        init = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Random operations with inputs scrambled after acceptance.
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, (1 << W) - 1)),
                   int'($urandom_range(0, (1 << W) - 1)),
                   1'($urandom), 1'b1);
        end

        // Exhaustive sweep of both operations.
        for (int o = 0; o < 2; o++) begin
            for (int a = 0; a < (1 << W); a++) begin
                for (int b = 0; b < (1 << W); b++) begin
                    run_op(a, b, 1'(o), 1'((a ^ b) & 1));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial add/subtract controller for the ALU lab. It latches two WIDTH-bit operands and an operation code, then drives a single internal 1-bit full add/subtract cell one bit per clock, LSB first. It assembles the result and the carry/borrow, overflow and zero flags, and reports completion with a one-cycle done pulse. It sits between the ALU operation decoder and the result/flag registers, replacing a WIDTH-bit parallel ripple chain with one reused cell.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..16.

- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- init  input  1  start request; sampled only in IDLE
- op  input  1  0 = A+B, 1 = A−B; latched with operands
- A  input  WIDTH  minuend / first addend; latched on accepted init
- B  input  WIDTH  subtrahend / second addend; latched on accepted init
- result  output  WIDTH  registered result; held until the next completion
- cout  output  1  add: carry out; sub: borrow (1 when A<B unsigned)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  1 when result == 0
- busy  output  1  1 while in RUN
- done  output  1  one-cycle pulse in DONE state

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when init=1 at a clock edge:
  - latch A into shift register sa and B into sb, with sb = ~B when op=1;
  - preload carry c = op (1 for subtract);
  - clear bit counter cnt and partial shift register sr.
- RUN, each edge:
  - s = sa[0]^sb[0]^c; c_next = majority(sa[0], sb[0], c);
  - shift sa and sb right; shift s into sr MSB;
  - record c as c_msb_in when cnt == WIDTH−1;
  - cnt increments.
- RUN → DONE on the edge that processes bit WIDTH−1. On that same edge, update registers from the final values:
  - result = final sr;
  - cout = c_final ^ op;
  - ovf = c_msb_in ^ c_final;
  - zero = (final sr == 0).
- DONE → IDLE unconditionally on the next edge.
- init is ignored in RUN and DONE. A request is never queued; a held init in IDLE after DONE starts a new operation.
- A, B and op may change freely after acceptance without effect.
- All arithmetic is modulo 2^WIDTH. The cnt width is ceil(log2(WIDTH))+1 and must not wrap before WIDTH bits are processed.
- rst asserted at any time, including mid-RUN:
  - state = IDLE;
  - result = 0, cout = 0, ovf = 0, zero = 0, busy = 0, done = 0;
  - internal shift registers and cnt cleared;
  - the partial operation is discarded and no done is produced.

## Timing
- Edge E0 samples init=1 in IDLE; busy=1 from E0 through edge E(WIDTH).
- Bits 0..WIDTH−1 are processed on edges E1..E(WIDTH).
- result and flags become valid after E(WIDTH). done=1 for exactly the cycle between E(WIDTH) and E(WIDTH+1).
- Latency from init acceptance to done is WIDTH+1 edges. Throughput is one operation per WIDTH+2 cycles with init held high.
- result and flags keep their values after DONE until the next completion. They never show partial values.
- busy and done are never high together. busy and done are decoded from the registered state (Moore outputs).

## Test plan
- WIDTH=4: op=0, A=5, B=3 → after 5 edges: result=8, cout=0, ovf=1, zero=0, done pulse of exactly 1 cycle.
- op=1, A=3, B=5 → result=14 (4'b1110), cout=1 (borrow), ovf=0, zero=0. Then op=1, A=7, B=7 → result=0, zero=1, cout=0.
- op=0, A=15, B=1 → result=0, cout=1, zero=1, ovf=0. Then op=1, A=8, B=1 → result=7, ovf=1, cout=0.
- Pulse init again on the edge after acceptance and change A/B mid-RUN → no restart, result from the originally latched operands, exactly one done.
- Assert rst for 1 cycle at the 2nd RUN edge → all outputs 0 immediately (asynchronous), no done. A fresh init then gives a correct result after WIDTH+1 edges.
- Hold init=1 continuously with fixed operands → done every WIDTH+2 cycles. Sweep all 256 A/B pairs for both op values against a reference model (WIDTH=4).
